apb4_regfile: RTL and testbench



---
 rtl/apb4_regfile_pkg.sv | 50 +++++
 rtl/apb4_wait_ctr.sv | 31 +++
 rtl/apb4_regfile.sv | 128 ++++++++++++
 tb/tb_apb4_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_regfile_pkg.sv
// Shared types and decode helper for the APB4 register file.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package apb4_regfile_pkg;

  // The latched request is sized for the widest supported bus; narrower
  // instances zero-extend into it and use only the low bits.
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_STRB_W = REQ_DATA_W / 8;

  // Upper bound on register count, so the masks can be passed to decode_err
  // as fixed-width vectors.
  localparam int MAX_DEPTH = 256;

  // Wait counter width; covers WAIT_STATES up to 15.
  localparam int WAIT_CNT_W = 4;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  write;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_STRB_W-1:0] strb;
    logic                  priv;
  } apb_req_t;

  // Error for a latched request: misaligned, out of range,
  // privilege violation, or write to a read-only register.
  function automatic logic decode_err(
    input logic [REQ_ADDR_W-1:0] addr,
    input logic                  write,
    input logic                  priv,
    input logic [MAX_DEPTH-1:0]  ro_mask,
    input logic [MAX_DEPTH-1:0]  priv_mask,
    input int unsigned           addr_lsb,
    input int unsigned           depth
  );
    logic [REQ_ADDR_W-1:0] low_mask;
    logic [REQ_ADDR_W-1:0] idx;
    logic misal, oor, priv_viol, ro_wr;
    low_mask  = (REQ_ADDR_W'(1) << addr_lsb) - REQ_ADDR_W'(1);
    misal     = |(addr & low_mask);
    idx       = addr >> addr_lsb;
    oor       = (idx >= depth);
    priv_viol = !oor && priv_mask[idx[7:0]] && !priv;
    ro_wr     = !oor && write && ro_mask[idx[7:0]];
    return misal | oor | priv_viol | ro_wr;
  endfunction

endpackage

// File: rtl/apb4_wait_ctr.sv
// Counts ACCESS cycles and raises ready after WAIT_STATES stalled cycles.
// Latency: ready asserts in ACCESS cycle WAIT_STATES+1 (combinational output).
// Backpressure: holds its count while access is low; cleared by every SETUP.
module apb4_wait_ctr
  import apb4_regfile_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic setup,
  input  logic access,
  output logic ready
);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  assign ready = access && (wait_cnt == WAIT_CNT_W'(WAIT_STATES));

  // Clear on SETUP, advance once per stalled ACCESS cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (setup) begin
      wait_cnt <= '0;
    end else if (access && !ready) begin
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb4_regfile.sv
// APB4 slave register bank with byte strobes, privilege/read-only checks and PSLVERR.
// Latency: PREADY in ACCESS cycle WAIT_STATES+1; read data and error are combinational.
// Backpressure: PREADY low for WAIT_STATES ACCESS cycles; dropping PSEL abandons the transfer.
module apb4_regfile
  import apb4_regfile_pkg::*;
#(
  parameter int               DATA_W      = 32,
  parameter int               ADDR_W      = 8,
  parameter int               DEPTH       = 16,
  parameter int               WAIT_STATES = 0,
  parameter logic [DEPTH-1:0] RO_MASK     = '0,
  parameter logic [DEPTH-1:0] PRIV_MASK   = '0,
  parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  input  logic [2:0]          PPROT,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int MI_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MAX_DEPTH-1:0] RO_EXT   = MAX_DEPTH'(RO_MASK);
  localparam logic [MAX_DEPTH-1:0] PRIV_EXT = MAX_DEPTH'(PRIV_MASK);

  // Illegal parameterisations stop elaboration.
  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
    $fatal(1, "apb4_regfile: DATA_W must be 8, 16 or 32");
  end
  if (ADDR_W <= ADDR_LSB || ADDR_W > REQ_ADDR_W) begin : g_bad_addr_w
    $fatal(1, "apb4_regfile: ADDR_W out of range");
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH ||
      ((ADDR_W - ADDR_LSB) < 9 && DEPTH > (1 << (ADDR_W - ADDR_LSB)))) begin : g_bad_depth
    $fatal(1, "apb4_regfile: DEPTH exceeds address space");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $fatal(1, "apb4_regfile: WAIT_STATES must be 0..15");
  end

  apb_req_t          req;
  logic              setup;
  logic              access;
  logic              active;
  logic              ready;
  logic              err;
  logic              commit;
  logic [MI_W-1:0]   mem_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_pprot;

  // Only the privileged bit of PPROT takes part in decode.
  assign unused_pprot = ^PPROT[2:1];

  assign setup  = PSEL && !PENABLE;
  // An ACCESS only counts if a SETUP opened it, so a master that holds
  // PENABLE through reset or past completion cannot trigger a stray commit.
  assign access = PSEL && PENABLE && active;

  apb4_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .setup  (setup),
    .access (access),
    .ready  (ready)
  );

  // Track whether a SETUP-opened transfer is still in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      active <= 1'b0;
    end else if (setup) begin
      active <= 1'b1;
    end else if (ready || !PSEL) begin
      active <= 1'b0;
    end
  end

  // Capture the request in SETUP; ACCESS-phase bus changes are ignored.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req <= '0;
    end else if (setup) begin
      req.addr  <= REQ_ADDR_W'(PADDR);
      req.write <= PWRITE;
      req.wdata <= REQ_DATA_W'(PWDATA);
      req.strb  <= REQ_STRB_W'(PSTRB);
      req.priv  <= PPROT[0];
    end
  end

  assign mem_idx = MI_W'(req.addr >> ADDR_LSB);
  assign err     = decode_err(req.addr, req.write, req.priv, RO_EXT, PRIV_EXT,
                              ADDR_LSB, DEPTH);
  assign commit  = ready && req.write && !err;

  // Register array: reset to RESET_VAL, byte-lane writes on a clean completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (req.strb[b]) begin
          mem[mem_idx][8*b +: 8] <= req.wdata[8*b +: 8];
        end
      end
    end
  end

  assign PREADY  = ready;
  assign PSLVERR = ready && err;
  // Read data is only driven on a clean read completion, otherwise zero.
  assign PRDATA  = (ready && !req.write && !err) ? mem[mem_idx] : '0;

endmodule

// File: tb/tb_apb4_regfile.sv
module tb_apb4_regfile;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   waits  = 0;

  apb4_regfile #(
    .DATA_W     (32),
    .ADDR_W     (8),
    .DEPTH      (16),
    .WAIT_STATES(2),
    .RO_MASK    (16'h8000),
    .PRIV_MASK  (16'h4000),
    .RESET_VAL  (32'h0)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PSTRB  (PSTRB),
    .PPROT  (PPROT),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge and checks every completion
  // against the oldest expected response.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      waits = 0;
      check("reset_ctl", {30'b0, PREADY, PSLVERR}, 32'h0);
      check("reset_rdata", PRDATA, 32'h0);
    end else if (PSEL && !PENABLE) begin
      waits = 0;
      check("setup_ctl", {30'b0, PREADY, PSLVERR}, 32'h0);
      check("setup_rdata", PRDATA, 32'h0);
    end else if (PSEL && PENABLE) begin
      if (!PREADY) begin
        waits++;
        check("wait_slverr", {31'b0, PSLVERR}, 32'h0);
        check("wait_rdata", PRDATA, 32'h0);
      end else if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_completion: actual 1 required 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pslverr", {31'b0, PSLVERR}, {31'b0, e.err});
        check("prdata", PRDATA, e.rdata);
        check("wait_states", waits, 32'd2);
      end
    end else begin
      check("idle_ctl", {30'b0, PREADY, PSLVERR}, 32'h0);
      check("idle_rdata", PRDATA, 32'h0);
    end
  end

  task automatic idle(input int n);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // One transfer, entered and left at posedge+1. With corrupt=1 the bus
  // fields are scrambled during ACCESS; the DUT must use SETUP values.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input logic exp_err, input logic [31:0] exp_rdata,
                      input logic corrupt);
    exp_t e;
    int   n;
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = addr;
    PWDATA = wdata;
    PSTRB = strb;
    PPROT = prot;
    e.err = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    if (corrupt) begin
      PADDR = addr + 8'h04;
      PWDATA = ~wdata;
      PSTRB = 4'hF;
      PPROT = ~prot;
    end
    n = 0;
    while (!PREADY && n < 20) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    n_cmp++;
    if (!PREADY) begin
      n_fail++;
      $display("FAIL pready_timeout: actual 0 required 1 (addr %h)", addr);
      PSEL = 1'b0;
      PENABLE = 1'b0;
      sb.delete();
    end
    @(posedge PCLK);
    #1;
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESETn = 1'b0;
    PSEL = 1'b0;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = '0;
    PWDATA = '0;
    PSTRB = '0;
    PPROT = '0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    idle(2);

    // 1: full write then read
    xfer(1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0, 0);        idle(1);
    xfer(0, 8'h04, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0); idle(1);
    // 2: partial strobes
    xfer(1, 8'h08, 32'h11223344, 4'b0101, 3'b000, 0, 32'h0, 0);     idle(1);
    xfer(0, 8'h08, 32'h0,        4'hF, 3'b000, 0, 32'h00220044, 0); idle(1);
    // zero strobe: legal, no change
    xfer(1, 8'h08, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 32'h0, 0);        idle(1);
    xfer(0, 8'h08, 32'h0,        4'h0, 3'b000, 0, 32'h00220044, 0); idle(1);
    // 3: error cases
    xfer(1, 8'h3C, 32'h12345678, 4'hF, 3'b000, 1, 32'h0, 0);        idle(1);
    xfer(0, 8'h3C, 32'h0,        4'h0, 3'b000, 0, 32'h0, 0);        idle(1);
    xfer(0, 8'h40, 32'h0,        4'h0, 3'b001, 1, 32'h0, 0);        idle(1);
    xfer(1, 8'h05, 32'hCAFEF00D, 4'hF, 3'b000, 1, 32'h0, 0);        idle(1);
    xfer(0, 8'h04, 32'h0,        4'h0, 3'b000, 0, 32'hDEADBEEF, 0); idle(1);
    xfer(0, 8'h06, 32'h0,        4'h0, 3'b000, 1, 32'h0, 0);        idle(1);
    // 4: privilege
    xfer(1, 8'h38, 32'hA5A5A5A5, 4'hF, 3'b000, 1, 32'h0, 0);        idle(1);
    xfer(0, 8'h38, 32'h0,        4'h0, 3'b001, 0, 32'h0, 0);        idle(1);
    xfer(1, 8'h38, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 32'h0, 0);        idle(1);
    xfer(0, 8'h38, 32'h0,        4'h0, 3'b001, 0, 32'hA5A5A5A5, 0); idle(1);
    xfer(0, 8'h38, 32'h0,        4'h0, 3'b000, 1, 32'h0, 0);        idle(1);
    // 5: back-to-back, then ACCESS-phase bus changes
    xfer(1, 8'h00, 32'h01010101, 4'hF, 3'b000, 0, 32'h0, 0);
    xfer(1, 8'h04, 32'h02020202, 4'hF, 3'b000, 0, 32'h0, 0);
    xfer(0, 8'h00, 32'h0,        4'h0, 3'b000, 0, 32'h01010101, 0);
    xfer(0, 8'h04, 32'h0,        4'h0, 3'b000, 0, 32'h02020202, 0); idle(1);
    xfer(1, 8'h10, 32'h5555AAAA, 4'hF, 3'b000, 0, 32'h0, 1);        idle(1);
    xfer(0, 8'h10, 32'h0,        4'h0, 3'b000, 0, 32'h5555AAAA, 1); idle(1);
    xfer(0, 8'h14, 32'h0,        4'h0, 3'b000, 0, 32'h0, 0);        idle(1);

    // 6: reset in the 2nd ACCESS cycle of a write to 0x0C
    PSEL = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b1;
    PADDR = 8'h0C;
    PWDATA = 32'h77777777;
    PSTRB = 4'hF;
    PPROT = 3'b000;
    @(posedge PCLK);
    #1;
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    check("rst_pready", {31'b0, PREADY}, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    PSEL = 1'b0;
    PENABLE = 1'b0;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    idle(1);
    xfer(0, 8'h0C, 32'h0, 4'h0, 3'b000, 0, 32'h0, 0); idle(1);
    xfer(0, 8'h04, 32'h0, 4'h0, 3'b000, 0, 32'h0, 0); idle(1);
    xfer(0, 8'h38, 32'h0, 4'h0, 3'b001, 0, 32'h0, 0); idle(1);
    xfer(1, 8'h0C, 32'h0BADF00D, 4'hF, 3'b000, 0, 32'h0, 0);
    xfer(0, 8'h0C, 32'h0, 4'h0, 3'b000, 0, 32'h0BADF00D, 0);

    idle(3);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
